oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
// - Sprite DMA controller and CPU bus arbiter. Sits between the CPU core and the system address/data bus.
// - A CPU write to $4014 latches a source page. The block then halts the CPU via cpu_rdy and owns the bus.
// - It copies 256 bytes {page,00..FF} to the PPU OAM data port $2004 (read/write pairs), then returns the bus.
// - Outside a transfer it is a transparent pass-through of the CPU bus.
// PARAMETERS
// - DMA_REG_ADDR   16'h4014  CPU write address that triggers a transfer (data = source page)
// - OAM_DATA_ADDR  16'h2004  destination address of every DMA write cycle
// - XFER_LEN       256       bytes per transfer; offset counter is 8 bits, must stay 256
// PORTS
// - clk_ph2        in   1   sole clock; all state updates on rising edge
// - rst            in   1   synchronous, active-low reset (0 = reset)
// - cpu_addr       in   16  CPU address bus
// - cpu_dout       in   8   CPU write data
// - cpu_rw         in   1   CPU direction, 1 = read, 0 = write
// - bus_din        in   8   read data returned from system bus
// - bus_addr       out  16  system address (mux: CPU or DMA)
// - bus_dout       out  8   system write data (mux: CPU or DMA latch)
// - bus_rw         out  1   system direction, 1 = read
// - cpu_rdy        out  1   0 = CPU stalled
// - dma_active     out  1   1 while DMA owns the bus (ALIGN/READ/WRITE)
// BEHAVIOUR
// - Reset (rst=0 at edge): state=IDLE, page=0, offset=0, data_lat=0, parity=0; cpu_rdy=1, dma_active=0; bus_* = cpu_*.
// - parity: 1-bit toggle, flips every clk_ph2 edge out of reset. It defines even (0) and odd (1) cycles.
// - Trigger: in IDLE, cpu_addr==DMA_REG_ADDR && cpu_rw==0 -> page<=cpu_dout, offset<=0, next=HALT.
//   The CPU write itself passes through to the bus unchanged.
// - FSM, evaluated each edge:
//   IDLE  : cpu_rdy=1, pass-through; on trigger -> HALT.
//   HALT  : cpu_rdy=0, pass-through. The CPU cannot stall on a write: stay while cpu_rw==0.
//           When cpu_rw==1: parity==1 -> ALIGN; parity==0 -> READ.
//   ALIGN : cpu_rdy=0, dma_active=1; bus_addr={page,offset}, bus_rw=1 (dummy read, data discarded) -> READ.
//   READ  : bus_addr={page,offset}, bus_rw=1; data_lat<=bus_din at edge -> WRITE.
//   WRITE : bus_addr=OAM_DATA_ADDR, bus_dout=data_lat, bus_rw=0.
//           offset==8'hFF -> IDLE (cpu_rdy=1 from next cycle); else offset<=offset+1 -> READ.
// - Timing: cpu_rdy low from the cycle after the $4014 write until WRITE of offset FF completes.
//   DMA-owned cycles = 512 + 1 if ALIGN taken; plus HALT cycles (>=1).
//   Typical stall = 513 (even) / 514 (odd).
// - The bus mux is combinational on state; every register is updated only on clk_ph2.
// - cpu_rdy and dma_active are combinational decodes of state (glitch-free: state is registered).
// - Boundaries:
//   - Writes to $4014 while state!=IDLE are ignored: no relatch, no restart.
//   - offset wraps only at end of transfer. Page FF reads FF00..FFFF with no carry into the high byte.
//   - Reset mid-transfer aborts immediately: IDLE, cpu_rdy=1, OAM left partially written.
//   - CPU reads of $4014 are not triggers.
//   - A write to $4014 in the same cycle reset deasserts is taken only if rst=1 at that edge.
// STRUCTURE
// - Shared package nes_bus_pkg: APU_OAMDMA/PPU_OAMDATA address constants, dma_state_t (IDLE,HALT,ALIGN,READ,WRITE).
// - Single module. No sub-module; parity toggle, offset counter and data latch inline. Target ~150-250 lines.
// TESTING
// - Reset: hold rst=0 4 cycles, drive cpu_addr=1234,rw=1 -> bus_addr=1234, cpu_rdy=1, dma_active=0.
// - Even start: write 8'h02 to $4014 with parity landing even at HALT exit, memory[0200+i]=i^8'h5A
//   -> 256 writes to $2004 with data i^5A in order, stall exactly 513 cycles.
// - Odd start: same but HALT exit on parity 1 -> one dummy read of $0200, then identical sequence, stall 514.
// - Halt on write: after trigger, hold cpu_rw=0 for 2 extra cycles -> remains HALT, pass-through, DMA starts only after cpu_rw=1.
// - Retrigger/wrap: page=8'hFF, write $4014=8'h05 at offset 10 -> ignored.
//   Last read addr FFFF, then cpu_rdy=1.
// - Reset mid-op: pull rst=0 at offset 8'h40 -> next edge IDLE, cpu_rdy=1, no further $2004 writes.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: register addresses, sprite DMA
// transfer length and the OAM DMA controller state encoding.
package nes_bus_pkg;

    localparam logic [15:0] APU_OAMDMA  = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;
    localparam int          XFER_LEN    = 256;

    // Offset of the final byte; the 8-bit offset counter ends here.
    localparam logic [7:0]  LAST_OFF    = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA controller and CPU bus arbiter. A CPU write to DMA_REG_ADDR
// latches a source page, stalls the CPU and copies 256 bytes
// {page,00..FF} to OAM_DATA_ADDR as read/write pairs; otherwise the CPU
// bus passes straight through.
// Ports:
//   clk_ph2    : clock, all state on rising edge
//   rst        : synchronous active-low reset
//   cpu_addr   : CPU address       cpu_dout : CPU write data
//   cpu_rw     : CPU dir, 1=read   bus_din  : system read data
//   bus_addr   : system address    bus_dout : system write data
//   bus_rw     : system dir        cpu_rdy  : 0 = CPU stalled
//   dma_active : DMA owns the bus (ALIGN/READ/WRITE)
module oam_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = APU_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA
) (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    output logic        cpu_rdy,
    output logic        dma_active
);

    dma_state_t state_q, state_d;
    logic [7:0] page_q,   page_d;
    logic [7:0] offset_q, offset_d;
    logic [7:0] data_q,   data_d;
    logic       parity_q;

    always_ff @(posedge clk_ph2) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            offset_q <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            offset_q <= offset_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        offset_d   = offset_q;
        data_d     = data_q;
        bus_addr   = cpu_addr;
        bus_dout   = cpu_dout;
        bus_rw     = cpu_rw;
        cpu_rdy    = 1'b0;
        dma_active = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cpu_rdy = 1'b1;
                if (cpu_addr == DMA_REG_ADDR && !cpu_rw) begin
                    page_d   = cpu_dout;
                    offset_d = 8'h00;
                    state_d  = ST_HALT;
                end
            end
            ST_HALT: begin
                // A CPU write cannot be stalled; wait for a read cycle.
                // Odd cycles need one dummy read to land READ on even.
                if (cpu_rw)
                    state_d = parity_q ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                dma_active = 1'b1;
                bus_addr   = {page_q, offset_q};
                bus_dout   = data_q;
                bus_rw     = 1'b1;
                state_d    = ST_READ;
            end
            ST_READ: begin
                dma_active = 1'b1;
                bus_addr   = {page_q, offset_q};
                bus_dout   = data_q;
                bus_rw     = 1'b1;
                data_d     = bus_din;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                dma_active = 1'b1;
                bus_addr   = OAM_DATA_ADDR;
                bus_dout   = data_q;
                bus_rw     = 1'b0;
                // Offset never carries into the page byte.
                offset_d   = offset_q + 8'h01;
                if (offset_q == LAST_OFF)
                    state_d = ST_IDLE;
                else
                    state_d = ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: a driver pushes the expected
// DMA bus cycles and stall lengths, a negedge monitor pops and compares.
module tb_oam_dma_arbiter;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
    } exp_t;

    logic        clk_ph2;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_rw;
    logic        cpu_rdy;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q[$];
    int          stall_q[$];
    int          checks;
    int          errors;
    int          edge_n;
    int          wr_seen;
    int          low_cnt;

    oam_dma_arbiter dut (
        .clk_ph2    (clk_ph2),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rw     (cpu_rw),
        .bus_din    (bus_din),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_rw     (bus_rw),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active)
    );

    assign bus_din = mem[bus_addr];

    initial clk_ph2 = 1'b0;
    always #5 clk_ph2 = ~clk_ph2;

    // Index of the next rising edge since reset; its parity is the
    // even/odd cycle the arbiter sees at that edge.
    always @(posedge clk_ph2) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom);
        while (a == 16'h4014) a = 16'($urandom);
        return a;
    endfunction

    always @(negedge clk_ph2) begin
        if (!rst) begin
            low_cnt = 0;
        end else begin
            if (dma_active) begin
                if (exp_q.size() == 0) begin
                    chk("dma_unexpected", {16'h0, bus_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dma_addr", {16'h0, bus_addr}, {16'h0, e.a});
                    chk("dma_rw", {31'h0, bus_rw}, {31'h0, e.rw});
                    if (!e.rw) begin
                        chk("dma_data", {24'h0, bus_dout}, {24'h0, e.d});
                        wr_seen++;
                    end
                end
            end else begin
                chk("passthru",
                    {7'h0, bus_addr, bus_dout, bus_rw},
                    {7'h0, cpu_addr, cpu_dout, cpu_rw});
            end
            if (!cpu_rdy) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (stall_q.size() == 0)
                    chk("stall_unexpected", low_cnt, 0);
                else
                    chk("stall_len", low_cnt, stall_q.pop_front());
                low_cnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_ph2);
        #1;
    endtask

    // Issue the $4014 write and queue the reference transfer.
    task automatic trigger(input logic [7:0] pg, input bit odd,
                           input int hold);
        int e;
        bit al;
        cpu_addr = rand_addr();
        cpu_rw   = 1'b1;
        if (((edge_n + 1 + hold) % 2) != int'(odd)) cyc();
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = pg;
        e  = edge_n + 1 + hold;
        al = (e % 2) == 1;
        if (al) exp_q.push_back('{{pg, 8'h00}, 1'b1, 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{{pg, 8'(i)}, 1'b1, 8'h00});
            exp_q.push_back('{16'h2004, 1'b0, mem[{pg, 8'(i)}]});
        end
        stall_q.push_back(hold + 1 + (al ? 1 : 0) + 512);
        wr_seen = 0;
        cyc();
        chk("trig_rdy", {31'h0, cpu_rdy}, 32'h0);
        for (int h = 0; h < hold; h++) begin
            cpu_addr = rand_addr();
            cpu_rw   = 1'b0;
            cpu_dout = 8'($urandom);
            cyc();
            chk("halt_rdy", {31'h0, cpu_rdy}, 32'h0);
            chk("halt_dma", {31'h0, dma_active}, 32'h0);
        end
        cpu_addr = rand_addr();
        cpu_rw   = 1'b1;
    endtask

    task automatic run_xfer(input logic [7:0] pg, input bit odd,
                            input int hold, input bit retrig);
        bit rt_done;
        bit done;
        rt_done = 1'b0;
        done    = 1'b0;
        trigger(pg, odd, hold);
        for (int n = 0; n < 800 && !done; n++) begin
            if (retrig && !rt_done && wr_seen >= 10) begin
                cpu_addr = 16'h4014;
                cpu_rw   = 1'b0;
                cpu_dout = 8'h05;
                rt_done  = 1'b1;
            end else begin
                cpu_addr = rand_addr();
                cpu_rw   = 1'b1;
            end
            cyc();
            done = cpu_rdy;
        end
        chk("xfer_done", {31'h0, cpu_rdy}, 32'h1);
        cpu_addr = rand_addr();
        cpu_rw   = 1'b1;
        repeat (3) cyc();
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_stall", stall_q.size(), 0);
        chk("wr_count", wr_seen, 256);
    endtask

    initial begin
        int w;
        checks   = 0;
        errors   = 0;
        wr_seen  = 0;
        low_cnt  = 0;
        rst      = 1'b0;
        cpu_addr = 16'h1234;
        cpu_rw   = 1'b1;
        cpu_dout = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        repeat (4) cyc();
        chk("rst_addr", {16'h0, bus_addr}, 32'h1234);
        chk("rst_rw", {31'h0, bus_rw}, 32'h1);
        chk("rst_rdy", {31'h0, cpu_rdy}, 32'h1);
        chk("rst_dma", {31'h0, dma_active}, 32'h0);

        // $4014 write sampled while reset is still low is not a trigger.
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = 8'h33;
        cyc();
        rst      = 1'b1;
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b1;
        cyc();
        chk("rst_edge_trig", {31'h0, cpu_rdy}, 32'h1);
        cyc();
        chk("rd_4014_trig", {31'h0, cpu_rdy}, 32'h1);

        run_xfer(8'h02, 1'b0, 0, 1'b0);
        run_xfer(8'h02, 1'b1, 0, 1'b0);
        run_xfer(8'($urandom), 1'($urandom), 2, 1'b0);
        run_xfer(8'hFF, 1'($urandom), 0, 1'b1);
        for (int k = 0; k < 3; k++)
            run_xfer(8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);

        // Reset in the middle of a transfer.
        trigger(8'($urandom), 1'($urandom), 0);
        for (int n = 0; n < 400 && wr_seen < 64; n++) cyc();
        chk("mid_reached", {31'h0, 1'(wr_seen >= 64)}, 32'h1);
        rst = 1'b0;
        cyc();
        chk("mid_rdy", {31'h0, cpu_rdy}, 32'h1);
        chk("mid_dma", {31'h0, dma_active}, 32'h0);
        chk("mid_addr", {16'h0, bus_addr}, {16'h0, cpu_addr});
        exp_q.delete();
        stall_q.delete();
        low_cnt = 0;
        rst = 1'b1;
        w = wr_seen;
        repeat (30) cyc();
        chk("mid_no_writes", wr_seen, w);
        chk("mid_rdy_after", {31'h0, cpu_rdy}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
